// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants: byte width, header fields, FIFO geometry
package router_pkg;

  localparam int DATA_W      = 8;
  localparam int HDR_LEN_MSB = 7;   // header payload-length field
  localparam int HDR_LEN_LSB = 2;
  localparam int ADDR_MSB    = 1;   // header destination-address field
  localparam int ADDR_LSB    = 0;
  localparam int NUM_PORTS   = 3;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = 4;
  localparam int CNT_W       = 7;   // payload length + parity fits in 7 bits

endpackage

// File: rtl/router_fifo_if.sv
// rtl/router_fifo_if.sv - per-port FIFO signal bundle
//  master: router_sync / client side (drives strobes and data_in)
//  slave : router_fifo side (drives data_out, full, empty)
interface router_fifo_if #(
  parameter int DATA_W = router_pkg::DATA_W
);
  logic              soft_reset;
  logic              write_enb;
  logic              read_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  wire  [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;

  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty
  );
endinterface

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-destination output FIFO of the 3-port packet router
//  clock  : rising-edge clock
//  resetn : asynchronous active-low reset
//  fif    : slave modport (soft_reset, write_enb, read_enb, lfd_state, data_in,
//           data_out, full, empty)
module router_fifo
  import router_pkg::*;
#(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int DEPTH  = router_pkg::FIFO_DEPTH,
  parameter int ADDR_W = router_pkg::FIFO_ADDR_W
) (
  input logic            clock,
  input logic            resetn,
  router_fifo_if.slave   fif
);

  // Each entry carries the header marker above the data byte.
  logic [DATA_W:0]   mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              oe_q, oe_d;    // data_out driven (not z)
  logic              drv_q, drv_d;  // data_out is showing read packet data

  logic              full, empty, do_wr, do_rd;
  logic [DATA_W:0]   rd_word;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  assign do_wr   = fif.write_enb && !full && !fif.soft_reset;
  assign do_rd   = fif.read_enb && !empty && !fif.soft_reset;
  assign rd_word = mem[rd_ptr_q[ADDR_W-1:0]];

  assign fif.full     = full;
  assign fif.empty    = empty;
  assign fif.data_out = oe_q ? dout_q : {DATA_W{1'bz}};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    oe_d     = oe_q;
    drv_d    = drv_q;
    if (fif.soft_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      oe_d     = 1'b0;
      drv_d    = 1'b0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_rd && rd_word[DATA_W]) begin
        // Header: remaining reads are the payload bytes plus the parity byte.
        cnt_d  = {1'b0, rd_word[HDR_LEN_MSB:HDR_LEN_LSB]} + 1'b1;
        dout_d = rd_word[DATA_W-1:0];
        oe_d   = 1'b1;
        drv_d  = 1'b1;
      end else if (do_rd && cnt_q != '0) begin
        cnt_d  = cnt_q - 1'b1;
        dout_d = rd_word[DATA_W-1:0];
        oe_d   = 1'b1;
        drv_d  = 1'b1;
      end else if (cnt_q == '0 && (do_rd || drv_q)) begin
        // Packet finished: the parity byte got its one cycle, now release the bus.
        // The post-reset 0 stays driven until packet data has been shown.
        oe_d  = 1'b0;
        drv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      oe_q     <= 1'b1;
      drv_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      oe_q     <= oe_d;
      drv_q    <= drv_d;
    end
  end

  // Storage array has no reset; contents after reset are don't-care.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr_q[ADDR_W-1:0]] <= {fif.lfd_state, fif.data_in};
  end

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - directed self-checking bench for router_fifo
module tb_router_fifo;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] zv;

  router_fifo_if #(.DATA_W(8)) fif ();

  router_fifo dut (
    .clock  (clock),
    .resetn (resetn),
    .fif    (fif.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic lfd);
    fif.write_enb = 1'b1;
    fif.data_in   = d;
    fif.lfd_state = lfd;
    tick();
    fif.write_enb = 1'b0;
    fif.lfd_state = 1'b0;
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", fif.empty); end
    n_checks++; if (fif.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", fif.full); end
    n_checks++; if (fif.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", fif.data_out); end
    tick();
    resetn = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (fif.data_out !== 8'h00) begin n_fail++; $display("FAIL idle_dout got %h want 00", fif.data_out); end
    n_checks++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL idle_empty got %b want 1", fif.empty); end
  endtask

  task automatic test_packet();
    logic [7:0] exp [5];
    exp[0] = 8'h0D; exp[1] = 8'hA1; exp[2] = 8'hA2; exp[3] = 8'hA3; exp[4] = 8'h5C;
    push(8'h0D, 1'b1);
    for (int i = 1; i < 5; i++) push(exp[i], 1'b0);
    n_checks++; if (fif.empty !== 1'b0) begin n_fail++; $display("FAIL pkt_not_empty got %b want 0", fif.empty); end
    fif.read_enb = 1'b1;
    #1;
    n_checks++; if (fif.data_out !== 8'h00) begin n_fail++; $display("FAIL pkt_latency got %h want 00", fif.data_out); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (fif.data_out !== exp[i]) begin n_fail++; $display("FAIL pkt_byte%0d got %h want %h", i, fif.data_out, exp[i]); end
    end
    n_checks++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL pkt_empty got %b want 1", fif.empty); end
    fif.read_enb = 1'b0;
    tick();
    n_checks++; if (fif.data_out !== zv) begin n_fail++; $display("FAIL pkt_float got %h want zz", fif.data_out); end
  endtask

  task automatic test_full_wrap();
    logic [7:0] base;
    logic [7:0] exp;
    for (int p = 0; p < 2; p++) begin
      base = (p == 0) ? 8'h10 : 8'h80;
      push(8'h38, 1'b1);
      for (int i = 1; i < 16; i++) push(base + 8'(i), 1'b0);
      n_checks++; if (fif.full !== 1'b1) begin n_fail++; $display("FAIL full%0d got %b want 1", p, fif.full); end
      push(8'hEE, 1'b0);
      n_checks++; if (fif.full !== 1'b1) begin n_fail++; $display("FAIL full_hold%0d got %b want 1", p, fif.full); end
      fif.read_enb = 1'b1;
      for (int i = 0; i < 16; i++) begin
        tick();
        exp = (i == 0) ? 8'h38 : base + 8'(i);
        n_checks++;
        if (fif.data_out !== exp) begin n_fail++; $display("FAIL drain%0d_%0d got %h want %h", p, i, fif.data_out, exp); end
      end
      n_checks++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty%0d got %b want 1", p, fif.empty); end
      tick();
      fif.read_enb = 1'b0;
      n_checks++; if (fif.data_out !== zv) begin n_fail++; $display("FAIL over_read%0d got %h want zz", p, fif.data_out); end
      n_checks++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL over_empty%0d got %b want 1", p, fif.empty); end
    end
  endtask

  task automatic test_simultaneous();
    push(8'h38, 1'b1);
    for (int i = 1; i < 16; i++) push(8'h40 + 8'(i), 1'b0);
    n_checks++; if (fif.full !== 1'b1) begin n_fail++; $display("FAIL sim_full got %b want 1", fif.full); end
    fif.read_enb = 1'b1; fif.write_enb = 1'b1; fif.data_in = 8'hFF; fif.lfd_state = 1'b0;
    tick();
    fif.read_enb = 1'b0; fif.write_enb = 1'b0;
    n_checks++; if (fif.data_out !== 8'h38) begin n_fail++; $display("FAIL sim_rd got %h want 38", fif.data_out); end
    n_checks++; if (fif.full !== 1'b0) begin n_fail++; $display("FAIL sim_notfull got %b want 0", fif.full); end
    fif.read_enb = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      n_checks++;
      if (fif.data_out !== 8'h40 + 8'(i)) begin n_fail++; $display("FAIL sim_drain%0d got %h want %h", i, fif.data_out, 8'h40 + 8'(i)); end
    end
    fif.read_enb = 1'b0;
    n_checks++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL sim_drop got empty=%b want 1", fif.empty); end
    tick();
    fif.read_enb = 1'b1; fif.write_enb = 1'b1; fif.data_in = 8'h04; fif.lfd_state = 1'b1;
    tick();
    fif.read_enb = 1'b0; fif.write_enb = 1'b0; fif.lfd_state = 1'b0;
    n_checks++; if (fif.data_out !== zv) begin n_fail++; $display("FAIL sim_nobypass got %h want zz", fif.data_out); end
    n_checks++; if (fif.empty !== 1'b0) begin n_fail++; $display("FAIL sim_stored got %b want 0", fif.empty); end
    fif.read_enb = 1'b1;
    tick();
    fif.read_enb = 1'b0;
    n_checks++; if (fif.data_out !== 8'h04) begin n_fail++; $display("FAIL sim_late_rd got %h want 04", fif.data_out); end
  endtask

  task automatic test_soft_reset();
    push(8'h1D, 1'b1);
    for (int i = 1; i < 8; i++) push(8'h20 + 8'(i), 1'b0);
    fif.read_enb = 1'b1;
    tick();
    n_checks++; if (fif.data_out !== 8'h1D) begin n_fail++; $display("FAIL sr_hdr got %h want 1D", fif.data_out); end
    tick();
    fif.read_enb = 1'b0;
    n_checks++; if (fif.data_out !== 8'h21) begin n_fail++; $display("FAIL sr_pay got %h want 21", fif.data_out); end
    fif.soft_reset = 1'b1; fif.write_enb = 1'b1; fif.data_in = 8'hEE;
    tick();
    fif.soft_reset = 1'b0; fif.write_enb = 1'b0;
    n_checks++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL sr_empty got %b want 1", fif.empty); end
    n_checks++; if (fif.data_out !== zv) begin n_fail++; $display("FAIL sr_float got %h want zz", fif.data_out); end
    n_checks++; if (fif.full !== 1'b0) begin n_fail++; $display("FAIL sr_full got %b want 0", fif.full); end
    push(8'h55, 1'b0);
    fif.read_enb = 1'b1;
    tick();
    fif.read_enb = 1'b0;
    n_checks++; if (fif.data_out !== zv) begin n_fail++; $display("FAIL sr_count got %h want zz", fif.data_out); end
    n_checks++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL sr_rd_empty got %b want 1", fif.empty); end
  endtask

  task automatic test_async_reset();
    push(8'h0D, 1'b1);
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    fif.read_enb = 1'b1;
    tick();
    n_checks++; if (fif.data_out !== 8'h0D) begin n_fail++; $display("FAIL ar_hdr got %h want 0D", fif.data_out); end
    #3 resetn = 1'b0;
    #1;
    n_checks++; if (fif.data_out !== 8'h00) begin n_fail++; $display("FAIL ar_dout got %h want 00", fif.data_out); end
    n_checks++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL ar_empty got %b want 1", fif.empty); end
    n_checks++; if (fif.full !== 1'b0) begin n_fail++; $display("FAIL ar_full got %b want 0", fif.full); end
    #2 fif.read_enb = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    n_checks++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL ar_post_empty got %b want 1", fif.empty); end
    n_checks++; if (fif.data_out !== 8'h00) begin n_fail++; $display("FAIL ar_post_dout got %h want 00", fif.data_out); end
  endtask

  initial begin
    zv             = 8'bzzzz_zzzz;
    fif.soft_reset = 1'b0;
    fif.write_enb  = 1'b0;
    fif.read_enb   = 1'b0;
    fif.lfd_state  = 1'b0;
    fif.data_in    = 8'h00;
    test_reset();
    test_packet();
    test_full_wrap();
    test_simultaneous();
    test_soft_reset();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
